// File: rtl/servo_pwm_multi.sv
// Centre-aligned multi-phase PWM with dead-time insertion, fault latch
// and double-buffered compare/period registers on an Avalon-MM slave.
module servo_pwm_multi #(
    parameter int NCH = 3,
    parameter int CW  = 16,
    parameter int DTW = 8
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic [5:0]     MMS_addr,
    input  logic           MMS_write,
    input  logic [31:0]    MMS_writedata,
    input  logic           MMS_read,
    output logic [31:0]    MMS_readdata,
    input  logic           fault_n,
    output logic [NCH-1:0] Udrive,
    output logic [NCH-1:0] Ldrive,
    output logic           irqout
);

    localparam logic [5:0] A_MAX  = 6'h20;
    localparam logic [5:0] A_DT   = 6'h21;
    localparam logic [5:0] A_CTRL = 6'h22;
    localparam logic [5:0] A_UPD  = 6'h23;
    localparam logic [5:0] A_FCLR = 6'h24;
    localparam logic [5:0] A_STAT = 6'h25;

    logic [CW-1:0]  sh_low   [NCH];
    logic [CW-1:0]  sh_high  [NCH];
    logic [CW-1:0]  act_low  [NCH];
    logic [CW-1:0]  act_high [NCH];
    logic [DTW-1:0] dc_u     [NCH];
    logic [DTW-1:0] dc_l     [NCH];
    logic [CW-1:0]  sh_max, act_max, ctr;
    logic [DTW-1:0] deadtime;
    logic [4:0]     ctrl;
    logic           countup, fault, pending;

    logic           enable, max_ev, zero_ev, apply;
    logic           upd_req, fclr_req, fault_set, fault_now;
    logic [NCH-1:0] raw_u, raw_l;
    logic [31:0]    status;
    logic           unused_wd;

    assign unused_wd = ^MMS_writedata;

    assign enable    = ctrl[4];
    assign max_ev    = enable && countup && (ctr == act_max);
    assign zero_ev   = enable && !countup && (ctr == '0);
    assign upd_req   = MMS_write && (MMS_addr == A_UPD) && MMS_writedata[0];
    assign fclr_req  = MMS_write && (MMS_addr == A_FCLR) && MMS_writedata[0];
    assign fault_set = enable && !fault_n;
    assign fault_now = fault || fault_set;

    // A stopped counter is parked at zero, so it counts as a zero point.
    assign apply = pending &&
                   ((max_ev && ctrl[1]) ||
                    ((zero_ev || !enable) && ctrl[0]));

    always_comb begin
        raw_u = '0;
        raw_l = '0;
        for (int k = 0; k < NCH; k++) begin
            raw_u[k] = ctr > act_high[k];
            raw_l[k] = ctr < act_low[k];
        end
    end

    always_comb begin
        status         = '0;
        status[CW-1:0] = ctr;
        status[29]     = countup;
        status[30]     = pending;
        status[31]     = fault;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int k = 0; k < NCH; k++) begin
                sh_low[k]   <= '0;
                sh_high[k]  <= '1;
                act_low[k]  <= '0;
                act_high[k] <= '1;
            end
            sh_max   <= '1;
            act_max  <= '1;
            deadtime <= '0;
            ctrl     <= '0;
            pending  <= 1'b0;
        end else begin
            if (MMS_write) begin
                for (int k = 0; k < NCH; k++) begin
                    if (MMS_addr == 6'(2 * k))
                        sh_low[k] <= MMS_writedata[CW-1:0];
                    if (MMS_addr == 6'(2 * k + 1))
                        sh_high[k] <= MMS_writedata[CW-1:0];
                end
                if (MMS_addr == A_MAX)
                    sh_max <= MMS_writedata[CW-1:0];
                if (MMS_addr == A_DT)
                    deadtime <= MMS_writedata[DTW-1:0];
                if (MMS_addr == A_CTRL)
                    ctrl <= MMS_writedata[4:0];
            end
            if (apply) begin
                for (int k = 0; k < NCH; k++) begin
                    act_low[k]  <= sh_low[k];
                    act_high[k] <= sh_high[k];
                end
                act_max <= sh_max;
            end
            pending <= upd_req || (pending && !apply);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ctr          <= '0;
            countup      <= 1'b1;
            fault        <= 1'b0;
            irqout       <= 1'b0;
            MMS_readdata <= '0;
        end else begin
            if (!enable) begin
                ctr     <= '0;
                countup <= 1'b1;
            end else if (countup) begin
                if (ctr == act_max) countup <= 1'b0;
                else                ctr     <= ctr + 1'b1;
            end else begin
                if (ctr == '0) countup <= 1'b1;
                else           ctr     <= ctr - 1'b1;
            end
            if (fault_set)
                fault <= 1'b1;
            else if (fclr_req && fault_n)
                fault <= 1'b0;
            irqout <= (zero_ev && ctrl[2]) || (max_ev && ctrl[3]) ||
                      (fault_set && !fault);
            MMS_readdata <= (MMS_read && MMS_addr == A_STAT) ? status : '0;
        end
    end

    // Each drive only turns on after its raw level has held for deadtime+1 cycles.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int k = 0; k < NCH; k++) begin
                dc_u[k] <= '0;
                dc_l[k] <= '0;
            end
            Udrive <= '0;
            Ldrive <= '0;
        end else begin
            for (int k = 0; k < NCH; k++) begin
                if (fault_now || !raw_u[k] || raw_l[k]) begin
                    dc_u[k]   <= '0;
                    Udrive[k] <= 1'b0;
                end else begin
                    Udrive[k] <= (dc_u[k] == deadtime);
                    if (dc_u[k] < deadtime) dc_u[k] <= dc_u[k] + 1'b1;
                end
                if (fault_now || !raw_l[k] || raw_u[k]) begin
                    dc_l[k]   <= '0;
                    Ldrive[k] <= 1'b0;
                end else begin
                    Ldrive[k] <= (dc_l[k] == deadtime);
                    if (dc_l[k] < deadtime) dc_l[k] <= dc_l[k] + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_servo_pwm_multi.sv
// Bench for servo_pwm_multi: phase table, randomized configs against a
// period-arithmetic model, and directed update/fault/reset sequences.
module tb_servo_pwm_multi;

    localparam int NCH = 3;

    logic           clk = 1'b0;
    logic           reset_n = 1'b0;
    logic [5:0]     MMS_addr = '0;
    logic           MMS_write = 1'b0;
    logic [31:0]    MMS_writedata = '0;
    logic           MMS_read = 1'b0;
    logic [31:0]    MMS_readdata;
    logic           fault_n = 1'b1;
    logic [NCH-1:0] Udrive, Ldrive;
    logic           irqout;

    servo_pwm_multi #(.NCH(NCH), .CW(16), .DTW(8)) dut (
        .clk(clk), .reset_n(reset_n),
        .MMS_addr(MMS_addr), .MMS_write(MMS_write),
        .MMS_writedata(MMS_writedata), .MMS_read(MMS_read),
        .MMS_readdata(MMS_readdata), .fault_n(fault_n),
        .Udrive(Udrive), .Ldrive(Ldrive), .irqout(irqout)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;
    int cfg_lo[NCH];
    int cfg_hi[NCH];

    typedef struct {
        int          p;
        logic [31:0] rd;
        logic        u;
        logic        l;
    } vec_t;
    vec_t vecs[20];

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        MMS_write = 1'b0;
        MMS_read = 1'b0;
        fault_n = 1'b1;
        repeat (2) tick();
        reset_n = 1'b1;
    endtask

    task automatic wr(logic [5:0] a, logic [31:0] d);
        MMS_read = 1'b0;
        MMS_addr = a;
        MMS_writedata = d;
        MMS_write = 1'b1;
        tick();
        MMS_write = 1'b0;
    endtask

    task automatic rd(logic [5:0] a, output logic [31:0] d);
        MMS_write = 1'b0;
        MMS_addr = a;
        MMS_read = 1'b1;
        tick();
        MMS_read = 1'b0;
        d = MMS_readdata;
    endtask

    task automatic stat_on();
        MMS_addr = 6'h25;
        MMS_read = 1'b1;
    endtask

    // Returns positioned in phase 0 of the first enabled period.
    task automatic configure(int m, int dt, logic [4:0] ctrl);
        do_reset();
        wr(6'h22, 32'h1);
        wr(6'h20, 32'(m));
        for (int k = 0; k < NCH; k++) begin
            wr(6'(2 * k), 32'(cfg_lo[k]));
            wr(6'(2 * k + 1), 32'(cfg_hi[k]));
        end
        wr(6'h21, 32'(dt));
        wr(6'h23, 32'h1);
        repeat (10) tick();
        wr(6'h22, {27'd0, ctrl});
        stat_on();
    endtask

    function automatic int ctr_at(int q, int m);
        int r;
        if (q < 0) return 0;
        r = q % (2 * m + 2);
        return (r <= m) ? r : 2 * m + 1 - r;
    endfunction

    function automatic int up_at(int q, int m);
        if (q < 0) return 1;
        return ((q % (2 * m + 2)) <= m) ? 1 : 0;
    endfunction

    // A drive is on iff its raw condition (and not the opposite) held for the last dt+1 cycles.
    function automatic bit exp_drive(int p, int m, int dt, int lo, int hi, bit upper);
        for (int j = 1; j <= dt + 1; j++) begin
            int c;
            bit ru, rl;
            c = ctr_at(p - j, m);
            ru = c > hi;
            rl = c < lo;
            if (upper ? !(ru && !rl) : !(rl && !ru)) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic run_model(int m, int dt, int n);
        logic [NCH-1:0] eu, el;
        logic [31:0] erd;
        for (int p = 0; p < n; p++) begin
            if (p > 0) tick();
            for (int k = 0; k < NCH; k++) begin
                eu[k] = exp_drive(p, m, dt, cfg_lo[k], cfg_hi[k], 1'b1);
                el[k] = exp_drive(p, m, dt, cfg_lo[k], cfg_hi[k], 1'b0);
            end
            chk("model_U", {29'd0, Udrive}, {29'd0, eu});
            chk("model_L", {29'd0, Ldrive}, {29'd0, el});
            chk("overlap", {29'd0, Udrive & Ldrive}, 32'd0);
            if (p > 0) begin
                erd = (32'(up_at(p - 1, m)) << 29) | 32'(ctr_at(p - 1, m));
                chk("model_stat", MMS_readdata, erd);
            end
        end
    endtask

    task automatic wait_peak(output int pk);
        logic prev_up;
        prev_up = 1'b0;
        pk = -1;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (prev_up && !MMS_readdata[29]) begin
                pk = int'(MMS_readdata[15:0]);
                return;
            end
            prev_up = MMS_readdata[29];
        end
    endtask

    initial begin
        logic [31:0] d;
        int pk, m, dt, found;

        vecs = '{
            '{0, 32'h00000000, 1'b0, 1'b1}, '{1, 32'h20000000, 1'b0, 1'b1},
            '{2, 32'h20000001, 1'b0, 1'b1}, '{3, 32'h20000002, 1'b0, 1'b1},
            '{4, 32'h20000003, 1'b0, 1'b0}, '{5, 32'h20000004, 1'b0, 1'b0},
            '{6, 32'h20000005, 1'b0, 1'b0}, '{7, 32'h20000006, 1'b1, 1'b0},
            '{8, 32'h20000007, 1'b1, 1'b0}, '{9, 32'h20000008, 1'b1, 1'b0},
            '{10, 32'h20000009, 1'b1, 1'b0}, '{11, 32'h00000009, 1'b1, 1'b0},
            '{12, 32'h00000008, 1'b1, 1'b0}, '{13, 32'h00000007, 1'b1, 1'b0},
            '{14, 32'h00000006, 1'b1, 1'b0}, '{15, 32'h00000005, 1'b0, 1'b0},
            '{16, 32'h00000004, 1'b0, 1'b0}, '{17, 32'h00000003, 1'b0, 1'b0},
            '{18, 32'h00000002, 1'b0, 1'b1}, '{19, 32'h00000001, 1'b0, 1'b1}
        };

        // Reset state
        do_reset();
        chk("rst_U", {29'd0, Udrive}, 32'd0);
        chk("rst_L", {29'd0, Ldrive}, 32'd0);
        chk("rst_irq", {31'd0, irqout}, 32'd0);
        chk("rst_rd", MMS_readdata, 32'd0);
        rd(6'h25, d);
        chk("rst_stat", d, 32'h20000000);
        rd(6'h10, d);
        chk("undef_rd", d, 32'd0);

        // Phase table: maxctr 9, high0 5, low0 3, dt 0; second period
        cfg_lo = '{3, 0, 0};
        cfg_hi = '{5, 65535, 65535};
        configure(9, 0, 5'h10);
        repeat (20) tick();
        for (int i = 0; i < 20; i++) begin
            chk($sformatf("tbl_U_p%0d", vecs[i].p), {31'd0, Udrive[0]}, {31'd0, vecs[i].u});
            chk($sformatf("tbl_L_p%0d", vecs[i].p), {31'd0, Ldrive[0]}, {31'd0, vecs[i].l});
            chk($sformatf("tbl_rd_p%0d", vecs[i].p), MMS_readdata, vecs[i].rd);
            tick();
        end

        // Dead time 2 with the same compares
        configure(9, 2, 5'h10);
        run_model(9, 2, 50);

        // Randomized configurations
        for (int r = 0; r < 6; r++) begin
            m = $urandom_range(1, 20);
            dt = $urandom_range(0, 4);
            for (int k = 0; k < NCH; k++) begin
                cfg_lo[k] = $urandom_range(0, m + 1);
                cfg_hi[k] = $urandom_range(0, m + 1);
            end
            configure(m, dt, 5'h10);
            run_model(m, dt, 4 * m + 10 + dt);
        end

        // Update at max event, maxctr 9 -> 4
        cfg_lo = '{3, 0, 0};
        cfg_hi = '{5, 65535, 65535};
        configure(9, 0, 5'h12);
        wr(6'h20, 32'd4);
        stat_on();
        wait_peak(pk);
        chk("peak_nopend", 32'(pk), 32'd9);
        wr(6'h23, 32'h1);
        stat_on();
        tick();
        chk("pend_set", {31'd0, MMS_readdata[30]}, 32'd1);
        wait_peak(pk);
        chk("peak_old", 32'(pk), 32'd9);
        wait_peak(pk);
        chk("peak_new", 32'(pk), 32'd4);
        chk("pend_clr", {31'd0, MMS_readdata[30]}, 32'd0);

        // Fault latch and clear
        configure(9, 0, 5'h10);
        repeat (8) tick();
        chk("pre_fault_U", {31'd0, Udrive[0]}, 32'd1);
        fault_n = 1'b0;
        tick();
        fault_n = 1'b1;
        chk("fault_U", {29'd0, Udrive}, 32'd0);
        chk("fault_L", {29'd0, Ldrive}, 32'd0);
        chk("fault_irq", {31'd0, irqout}, 32'd1);
        tick();
        chk("fault_irq_end", {31'd0, irqout}, 32'd0);
        repeat (12) tick();
        chk("fault_hold", {29'd0, Udrive | Ldrive}, 32'd0);
        chk("fault_stat", {31'd0, MMS_readdata[31]}, 32'd1);
        fault_n = 1'b0;
        wr(6'h24, 32'h1);
        fault_n = 1'b1;
        stat_on();
        repeat (2) tick();
        chk("fclr_ignored", {31'd0, MMS_readdata[31]}, 32'd1);
        chk("fclr_ign_drv", {29'd0, Udrive | Ldrive}, 32'd0);
        wr(6'h24, 32'h1);
        stat_on();
        tick();
        chk("fclr_done", {31'd0, MMS_readdata[31]}, 32'd0);
        found = 0;
        for (int i = 0; i < 40 && found == 0; i++) begin
            tick();
            if ((Udrive | Ldrive) != '0) found = 1;
        end
        chk("fault_resume", 32'(found), 32'd1);

        // maxctr 0 with both triggers
        cfg_lo = '{0, 0, 0};
        cfg_hi = '{65535, 65535, 65535};
        configure(0, 0, 5'h1C);
        chk("irq_m0_first", {31'd0, irqout}, 32'd0);
        for (int i = 1; i <= 10; i++) begin
            tick();
            chk($sformatf("irq_m0_c%0d", i), {31'd0, irqout}, 32'd1);
        end

        // Reset while running with a pending update
        cfg_lo = '{3, 0, 0};
        cfg_hi = '{5, 65535, 65535};
        configure(9, 0, 5'h10);
        repeat (8) tick();
        chk("pre_rst_U", {31'd0, Udrive[0]}, 32'd1);
        wr(6'h23, 32'h1);
        stat_on();
        reset_n = 1'b0;
        tick();
        chk("mid_rst_U", {29'd0, Udrive}, 32'd0);
        chk("mid_rst_L", {29'd0, Ldrive}, 32'd0);
        chk("mid_rst_irq", {31'd0, irqout}, 32'd0);
        chk("mid_rst_rd", MMS_readdata, 32'd0);
        reset_n = 1'b1;
        tick();
        chk("mid_rst_stat", MMS_readdata, 32'h20000000);
        MMS_read = 1'b0;

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
